jpeg_pixel_writer: RTL and testbench

//  Downstream stage of jpeg_top: consumes the MCU-ordered pixel stream (bo_* bus),

---
 rtl/jpeg_pixel_writer.sv | 204 ++++++++++++++++++++
 tb/tb_jpeg_pixel_writer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_pixel_writer.sv
`timescale 1ns/1ps
// jpeg_pixel_writer
//   Consumes the MCU-ordered pixel stream coming out of the JPEG decoder,
//   converts (MCU column, MCU row, in-MCU index) into raster x/y, clips the
//   pixel against the frame buffer window and issues one linear write per
//   in-window pixel. It gates the decoder with pix_next, tracks frame
//   start/finish, and keeps saturating counters of written and clipped pixels.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   start                    pulse, arms the block for one frame (from IDLE/DONE)
//   cfg_*                    decoder configuration, latched once per frame
//   pix_we/pix_end/pix_*     pixel stream from the decoder
//   pix_next                 ready back to the decoder (high only while running)
//   fb_we/fb_addr/fb_data    frame buffer write port, addr = y*FB_W + x
//   busy                     frame in progress (WAIT_CFG, RUN, FLUSH)
//   frame_done               level, set once the last pixel has been written
//   wr_count/clip_count      pixels written / dropped this frame, saturating
module jpeg_pixel_writer #(
  parameter int FB_W      = 32,
  parameter int FB_H      = 32,
  parameter int FB_ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cfg_en,
  input  logic                 cfg_411,
  input  logic [15:0]          cfg_width,
  input  logic [15:0]          cfg_height,
  input  logic [12:0]          cfg_mcu_w,
  input  logic [12:0]          cfg_mcu_h,
  input  logic                 pix_we,
  input  logic                 pix_end,
  input  logic [7:0]           pix_r,
  input  logic [7:0]           pix_g,
  input  logic [7:0]           pix_b,
  input  logic [7:0]           pix_adr,
  input  logic [12:0]          pix_x_mcu,
  input  logic [12:0]          pix_y_mcu,
  output logic                 pix_next,
  output logic                 fb_we,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [23:0]          fb_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic [15:0]          wr_count,
  output logic [15:0]          clip_count
);

  localparam logic [15:0]          FB_W16 = 16'(FB_W);
  localparam logic [15:0]          FB_H16 = 16'(FB_H);
  localparam logic [FB_ADDR_W-1:0] FB_W_A = FB_ADDR_W'(FB_W);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CFG,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t state;
  state_t state_next;
  logic   flush_cnt;

  // Latched configuration. The window limits already fold in the frame
  // buffer size so the clip test is a plain pair of compares.
  logic        mode_411;
  logic [15:0] win_w;
  logic [15:0] win_h;
  logic [12:0] last_x_mcu;
  logic [12:0] last_y_mcu;

  // Stage 1: raster coordinates and colour of the accepted beat.
  logic        s1_valid;
  logic [15:0] s1_x;
  logic [15:0] s1_y;
  logic [23:0] s1_rgb;

  logic        accept;
  logic        last_beat;
  logic        frame_start;
  logic [15:0] map_x;
  logic [15:0] map_y;
  logic        in_win;
  logic [FB_ADDR_W-1:0] lin_addr;

  assign pix_next    = (state == RUN);
  assign busy        = (state == WAIT_CFG) || (state == RUN) || (state == FLUSH);
  assign accept      = pix_we && pix_next;
  assign last_beat   = accept && pix_end &&
                       (pix_x_mcu == last_x_mcu) && (pix_y_mcu == last_y_mcu);
  assign frame_start = start && ((state == IDLE) || (state == DONE));

  // 16x16 MCU: adr = {row[3:0], col[3:0]}; 8x8 MCU: adr = {xx, row[2:0], col[2:0]}.
  // In 411 mode the top MCU bit falls off the 16-bit coordinate, which only
  // matters beyond 4095 MCUs.
  assign map_x = mode_411 ? {pix_x_mcu[11:0], pix_adr[3:0]} : {pix_x_mcu, pix_adr[2:0]};
  assign map_y = mode_411 ? {pix_y_mcu[11:0], pix_adr[7:4]} : {pix_y_mcu, pix_adr[5:3]};

  // Stage 2 combinational part. The address only has to be right for
  // in-window pixels, where y*FB_W+x always fits in FB_ADDR_W bits.
  assign in_win   = (s1_x < win_w) && (s1_y < win_h);
  assign lin_addr = FB_ADDR_W'(s1_y) * FB_W_A + FB_ADDR_W'(s1_x);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start)     state_next = WAIT_CFG;
      WAIT_CFG: if (cfg_en)    state_next = RUN;
      RUN:      if (last_beat) state_next = FLUSH;
      FLUSH:    if (flush_cnt) state_next = DONE;
      DONE:     if (start)     state_next = WAIT_CFG;
      default:                 state_next = IDLE;
    endcase
  end

  // FLUSH lasts exactly two cycles so the last beat leaves both stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt <= 1'b0;
    end else if (state == FLUSH) begin
      flush_cnt <= ~flush_cnt;
    end else begin
      flush_cnt <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_411   <= 1'b0;
      win_w      <= '0;
      win_h      <= '0;
      last_x_mcu <= '0;
      last_y_mcu <= '0;
    end else if ((state == WAIT_CFG) && cfg_en) begin
      mode_411   <= cfg_411;
      win_w      <= (cfg_width  < FB_W16) ? cfg_width  : FB_W16;
      win_h      <= (cfg_height < FB_H16) ? cfg_height : FB_H16;
      last_x_mcu <= cfg_mcu_w - 13'd1;
      last_y_mcu <= cfg_mcu_h - 13'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_rgb   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_x   <= map_x;
        s1_y   <= map_y;
        s1_rgb <= {pix_r, pix_g, pix_b};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      wr_count   <= '0;
      clip_count <= '0;
      frame_done <= 1'b0;
    end else begin
      fb_we <= s1_valid && in_win;
      if (s1_valid && in_win) begin
        fb_addr <= lin_addr;
        fb_data <= s1_rgb;
      end

      if (frame_start) begin
        wr_count   <= '0;
        clip_count <= '0;
      end else if (s1_valid) begin
        if (in_win) begin
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end else begin
          if (clip_count != 16'hFFFF) clip_count <= clip_count + 16'd1;
        end
      end

      if (frame_start) begin
        frame_done <= 1'b0;
      end else if ((state == FLUSH) && flush_cnt) begin
        frame_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_pixel_writer.sv
`timescale 1ns/1ps
module tb_jpeg_pixel_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cfg_en = 1'b0;
  logic        cfg_411 = 1'b0;
  logic [15:0] cfg_width = '0;
  logic [15:0] cfg_height = '0;
  logic [12:0] cfg_mcu_w = '0;
  logic [12:0] cfg_mcu_h = '0;
  logic        pix_we = 1'b0;
  logic        pix_end = 1'b0;
  logic [7:0]  pix_r = '0;
  logic [7:0]  pix_g = '0;
  logic [7:0]  pix_b = '0;
  logic [7:0]  pix_adr = '0;
  logic [12:0] pix_x_mcu = '0;
  logic [12:0] pix_y_mcu = '0;
  logic        pix_next;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [23:0] fb_data;
  logic        busy;
  logic        frame_done;
  logic [15:0] wr_count;
  logic [15:0] clip_count;

  jpeg_pixel_writer #(.FB_W(32), .FB_H(32), .FB_ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_en(cfg_en), .cfg_411(cfg_411),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_mcu_w(cfg_mcu_w), .cfg_mcu_h(cfg_mcu_h),
    .pix_we(pix_we), .pix_end(pix_end), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_adr(pix_adr), .pix_x_mcu(pix_x_mcu), .pix_y_mcu(pix_y_mcu),
    .pix_next(pix_next), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .frame_done(frame_done), .wr_count(wr_count), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [15:0] addr;
    logic [23:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [23:0] fb_mem [0:1023];
  int          wr_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pix_rgb(input logic [12:0] xm, input logic [12:0] ym,
                                          input logic [7:0] adr, input logic [7:0] tag);
    return {adr, xm[3:0], ym[3:0], tag};
  endfunction

  // Write monitor: every write must match the next in-window pixel of the model.
  always @(negedge clk) begin
    if (fb_we) begin
      wr_t e;
      wr_seen++;
      check("addr_in_fb", 32'(fb_addr < 16'd1024), 32'd1);
      check("done_low_while_writing", 32'(frame_done), 32'd0);
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(fb_addr), 32'(e.addr));
        check("wr_data", 32'(fb_data), 32'(e.data));
      end
      if (fb_addr < 16'd1024) fb_mem[fb_addr[9:0]] = fb_data;
    end
  end

  // Present one beat, let the next rising edge take it, return 1 ns later.
  task automatic drive_beat(input bit is411, input logic [12:0] xm, input logic [12:0] ym,
                            input logic [7:0] adr, input bit last, input logic [7:0] tag);
    int  x, y;
    wr_t e;
    logic [23:0] rgb;
    rgb = pix_rgb(xm, ym, adr, tag);
    if (is411) begin
      x = int'(xm) * 16 + int'(adr) % 16;
      y = int'(ym) * 16 + int'(adr) / 16;
    end else begin
      x = int'(xm) * 8 + int'(adr) % 8;
      y = int'(ym) * 8 + (int'(adr) / 8) % 8;
    end
    if (x < 32 && y < 32) begin
      e.addr = 16'(y * 32 + x);
      e.data = rgb;
      exp_q.push_back(e);
    end
    pix_we = 1'b1; pix_end = last;
    pix_x_mcu = xm; pix_y_mcu = ym; pix_adr = adr;
    pix_r = rgb[23:16]; pix_g = rgb[15:8]; pix_b = rgb[7:0];
    @(posedge clk); #1;
  endtask

  task automatic stream(input bit is411, input int mw, input int mh, input int first_idx,
                        input logic [7:0] tag);
    int n;
    n = is411 ? 256 : 64;
    for (int ym = 0; ym < mh; ym++)
      for (int xm = 0; xm < mw; xm++)
        for (int a = 0; a < n; a++) begin
          if (((ym * mw + xm) * n + a) >= first_idx)
            drive_beat(is411, 13'(xm), 13'(ym), is411 ? 8'(a) : (8'(a) | 8'h80),
                       (a == n - 1), tag);
        end
    pix_we = 1'b0; pix_end = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic set_cfg(input bit m411, input int w, input int h, input int mw, input int mh);
    cfg_411 = m411; cfg_width = 16'(w); cfg_height = 16'(h);
    cfg_mcu_w = 13'(mw); cfg_mcu_h = 13'(mh); cfg_en = 1'b1;
    @(posedge clk); #1 cfg_en = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!frame_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(frame_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pix_next", 32'(pix_next), 0);
    check("rst_fb_we", 32'(fb_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_fb_addr", 32'(fb_addr), 0);
    check("rst_fb_data", 32'(fb_data), 0);
    check("rst_wr_count", 32'(wr_count), 0);
    check("rst_clip_count", 32'(clip_count), 0);
    rst = 1'b1;

    // Pixels offered while idle are ignored
    pix_we = 1'b1; pix_end = 1'b1; pix_adr = 8'h00; pix_x_mcu = '0; pix_y_mcu = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_pix_next", 32'(pix_next), 0);

    // Still ignored in WAIT_CFG
    pulse_start();
    @(negedge clk);
    check("wait_busy", 32'(busy), 1);
    check("wait_pix_next", 32'(pix_next), 0);
    repeat (3) @(negedge clk);
    check("wait_no_writes", 32'(wr_seen), 0);
    check("wait_wr_count", 32'(wr_count), 0);
    check("wait_clip_count", 32'(clip_count), 0);
    pix_we = 1'b0; pix_end = 1'b0;

    // Frame 1: 411, 32x32, 2x2 MCUs
    @(posedge clk); #1;
    set_cfg(1'b1, 32, 32, 2, 2);
    @(negedge clk);
    check("run_pix_next", 32'(pix_next), 1);

    // First beat alone: write must appear exactly two cycles after accept
    drive_beat(1'b1, 13'd0, 13'd0, 8'h00, 1'b0, 8'h01);
    pix_we = 1'b0;
    @(negedge clk);
    check("lat_we_t1", 32'(fb_we), 0);
    @(negedge clk);
    check("lat_we_t2", 32'(fb_we), 1);
    check("lat_data_t2", 32'(fb_data), 32'(pix_rgb(13'd0, 13'd0, 8'h00, 8'h01)));
    check("lat_addr_t2", 32'(fb_addr), 0);
    @(negedge clk);
    check("lat_we_t3", 32'(fb_we), 0);

    stream(1'b1, 2, 2, 1, 8'h01);
    wait_done("f1_frame_done");
    check("f1_wr_count", 32'(wr_count), 1024);
    check("f1_clip_count", 32'(clip_count), 0);
    check("f1_busy", 32'(busy), 0);
    check("f1_writes_seen", 32'(wr_seen), 1024);
    check("f1_queue_empty", 32'(exp_q.size()), 0);
    check("f1_addr_561", 32'(fb_mem[561]), 32'(pix_rgb(13'd1, 13'd1, 8'h11, 8'h01)));

    // Beats offered in DONE are ignored
    pix_we = 1'b1;
    repeat (3) @(negedge clk);
    check("done_pix_next", 32'(pix_next), 0);
    check("done_wr_count", 32'(wr_count), 1024);
    pix_we = 1'b0;

    // Frame 2: start from DONE, non-411, 48x40, 6x5 MCUs
    pulse_start();
    @(negedge clk);
    check("f2_done_cleared", 32'(frame_done), 0);
    check("f2_busy", 32'(busy), 1);
    check("f2_wr_count_cleared", 32'(wr_count), 0);
    wr_seen = 0;
    @(posedge clk); #1;
    set_cfg(1'b0, 48, 40, 6, 5);
    // Config inputs must be ignored once running
    cfg_411 = 1'b1; cfg_width = 16'd8; cfg_height = 16'd8;
    cfg_mcu_w = 13'd1; cfg_mcu_h = 13'd1; cfg_en = 1'b1;
    stream(1'b0, 6, 5, 0, 8'h02);
    cfg_en = 1'b0;
    wait_done("f2_frame_done");
    check("f2_wr_count", 32'(wr_count), 1024);
    check("f2_clip_count", 32'(clip_count), 896);
    check("f2_writes_seen", 32'(wr_seen), 1024);
    check("f2_queue_empty", 32'(exp_q.size()), 0);

    // Frame 3: reset with beats in the pipe
    pulse_start();
    @(posedge clk); #1;
    set_cfg(1'b1, 32, 32, 2, 2);
    drive_beat(1'b1, 13'd0, 13'd0, 8'h00, 1'b0, 8'h03);
    drive_beat(1'b1, 13'd0, 13'd0, 8'h01, 1'b0, 8'h03);
    drive_beat(1'b1, 13'd0, 13'd0, 8'h02, 1'b0, 8'h03);
    check("mid_we_before_rst", 32'(fb_we), 1);
    rst = 1'b0;
    #1;
    check("mid_rst_fb_we", 32'(fb_we), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_pix_next", 32'(pix_next), 0);
    check("mid_rst_wr_count", 32'(wr_count), 0);
    check("mid_rst_fb_data", 32'(fb_data), 0);
    pix_we = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst_fb_we", 32'(fb_we), 0);
    pulse_start();
    @(negedge clk);
    check("restart_busy", 32'(busy), 1);
    check("restart_wr_count", 32'(wr_count), 0);
    @(posedge clk); #1;
    set_cfg(1'b1, 32, 32, 2, 2);
    drive_beat(1'b1, 13'd1, 13'd0, 8'h00, 1'b0, 8'h04);
    pix_we = 1'b0;
    repeat (3) @(negedge clk);
    check("restart_wr_one", 32'(wr_count), 1);
    check("restart_clip_zero", 32'(clip_count), 0);
    check("restart_queue_empty", 32'(exp_q.size()), 0);
    check("restart_addr", 32'(fb_addr), 16);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
